// File: rtl/tetris_pkg.sv
// tetris_pkg: shared playfield defaults, line-clear FSM states and score lookup.
package tetris_pkg;
   localparam int DEFAULT_WIDE = 10;
   localparam int DEFAULT_HIGH = 22;
   localparam int SCORE_W = 11;
   typedef enum logic [1:0] {ST_IDLE, ST_COMPACT, ST_FILL, ST_DONE} clear_state_t;
   function automatic logic [SCORE_W-1:0] score_for_rows(input int unsigned n);
      return n >= 4 ? SCORE_W'(1200) : n == 3 ? SCORE_W'(300) : n == 2 ? SCORE_W'(100) : n == 1 ? SCORE_W'(40) : '0;
   endfunction
endpackage

// File: rtl/row_clear_engine_if.sv
// row_clear_engine_if: job request and result bundle between piece-lock logic and the clear engine.
interface row_clear_engine_if #(
   parameter int BLOCKS_WIDE = tetris_pkg::DEFAULT_WIDE,
   parameter int BLOCKS_HIGH = tetris_pkg::DEFAULT_HIGH
);
   logic start;
   logic pause;
   logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_in;
   logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_out;
   logic busy;
   logic done;
   logic [$clog2(BLOCKS_HIGH+1)-1:0] rows_cleared;
   logic [BLOCKS_HIGH-1:0] clear_mask;
   logic [tetris_pkg::SCORE_W-1:0] score_delta;
   modport master(output start, pause, board_in, input board_out, busy, done, rows_cleared, clear_mask, score_delta);
   modport slave(input start, pause, board_in, output board_out, busy, done, rows_cleared, clear_mask, score_delta);
endinterface

// File: rtl/row_full_detect.sv
// row_full_detect: flags a playfield row whose every column is occupied.
module row_full_detect #(
   parameter int BLOCKS_WIDE = 10
) (
   input  logic [BLOCKS_WIDE-1:0] row,
   output logic                   full
);
   assign full = &row;
endmodule

// File: rtl/row_clear_engine.sv
// row_clear_engine: snapshots the board, removes full rows bottom-up in place,
// zero-fills the vacated top rows and reports count, mask and score.
module row_clear_engine
   import tetris_pkg::*;
#(
   parameter int BLOCKS_WIDE = DEFAULT_WIDE,
   parameter int BLOCKS_HIGH = DEFAULT_HIGH
) (
   input logic clk,
   input logic rst_n,
   row_clear_engine_if.slave bus
);
   localparam int PW = $clog2(BLOCKS_HIGH);
   localparam int CW = $clog2(BLOCKS_HIGH+1);
   clear_state_t state;
   logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board;
   logic [PW-1:0] rd, wr;
   logic [CW-1:0] cnt;
   logic [BLOCKS_HIGH-1:0] mask;
   logic [SCORE_W-1:0] score;
   logic full;
   row_full_detect #(.BLOCKS_WIDE(BLOCKS_WIDE)) u_detect (
      .row (board[rd*BLOCKS_WIDE +: BLOCKS_WIDE]),
      .full(full)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         board <= '0;
         rd <= '0;
         wr <= '0;
         cnt <= '0;
         mask <= '0;
         score <= '0;
      end else if (!bus.pause) begin
         case (state)
            ST_IDLE: if (bus.start) begin
               board <= bus.board_in;
               rd <= PW'(BLOCKS_HIGH-1);
               wr <= PW'(BLOCKS_HIGH-1);
               cnt <= '0;
               mask <= '0;
               score <= '0;
               state <= ST_COMPACT;
            end
            ST_COMPACT: begin
               // wr never drops below rd, so the row read here is still original
               if (full) begin
                  mask[rd] <= 1'b1;
                  cnt <= cnt + 1'b1;
               end else begin
                  if (wr != rd) board[wr*BLOCKS_WIDE +: BLOCKS_WIDE] <= board[rd*BLOCKS_WIDE +: BLOCKS_WIDE];
                  wr <= wr - 1'b1;
               end
               rd <= rd - 1'b1;
               if (rd == '0) begin
                  state <= (full || cnt != '0) ? ST_FILL : ST_DONE;
                  score <= score_for_rows(int'(cnt) + (full ? 1 : 0));
               end
            end
            ST_FILL: begin
               board[wr*BLOCKS_WIDE +: BLOCKS_WIDE] <= '0;
               wr <= wr - 1'b1;
               if (wr == '0) state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
   assign bus.board_out = board;
   assign bus.busy = state != ST_IDLE;
   assign bus.done = state == ST_DONE;
   assign bus.rows_cleared = cnt;
   assign bus.clear_mask = mask;
   assign bus.score_delta = score;
endmodule

// File: tb/tb_row_clear_engine.sv
// tb_row_clear_engine: scoreboarded scenarios for the line-clear engine against a row-filter model.
module tb_row_clear_engine;
   localparam int W = 10;
   localparam int H = 22;
   typedef logic [W*H-1:0] brd_t;
   typedef struct {
      brd_t board;
      int cnt;
      logic [H-1:0] mask;
      int score;
      int lat;
   } exp_t;
   logic clk = 0;
   logic rst_n = 0;
   int tests = 0;
   int fails = 0;
   exp_t q[$];
   row_clear_engine_if #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H)) bus ();
   row_clear_engine #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   function automatic brd_t put_row(input brd_t b, input int r, input logic [W-1:0] v);
      b[r*W +: W] = v;
      return b;
   endfunction
   function automatic exp_t model(input brd_t b, input int stretch);
      exp_t e;
      int w;
      logic [W-1:0] row;
      e.board = '0;
      e.cnt = 0;
      e.mask = '0;
      w = H - 1;
      for (int r = H - 1; r >= 0; r--) begin
         row = b[r*W +: W];
         if (&row) begin
            e.mask[r] = 1'b1;
            e.cnt++;
         end else begin
            e.board[w*W +: W] = row;
            w--;
         end
      end
      e.score = e.cnt == 0 ? 0 : e.cnt == 1 ? 40 : e.cnt == 2 ? 100 : e.cnt == 3 ? 300 : 1200;
      e.lat = H + e.cnt + 1 + stretch;
      return e;
   endfunction
   task automatic run_job(input brd_t b, input int p_at, input int p_len, input int s_at, input string nm);
      exp_t e;
      int c;
      q.push_back(model(b, p_len));
      bus.board_in = b;
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      c = 1;
      tests++;
      if (bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL %s busy_after_start: got %b want 1", nm, bus.busy);
      end
      while (!bus.done && c < 300) begin
         bus.pause = (c >= p_at && c < p_at + p_len);
         bus.start = (c == s_at);
         @(negedge clk);
         c++;
      end
      bus.pause = 0;
      bus.start = 0;
      e = q.pop_front();
      tests++;
      if (!bus.done) begin
         fails++;
         $display("FAIL %s done_timeout: no done after %0d cycles", nm, c);
      end else if (c != e.lat) begin
         fails++;
         $display("FAIL %s done_cycle: got %0d want %0d", nm, c, e.lat);
      end
      tests++;
      if (int'(bus.rows_cleared) != e.cnt) begin
         fails++;
         $display("FAIL %s rows_cleared: got %0d want %0d", nm, bus.rows_cleared, e.cnt);
      end
      tests++;
      if (bus.clear_mask !== e.mask) begin
         fails++;
         $display("FAIL %s clear_mask: got %h want %h", nm, bus.clear_mask, e.mask);
      end
      tests++;
      if (int'(bus.score_delta) != e.score) begin
         fails++;
         $display("FAIL %s score_delta: got %0d want %0d", nm, bus.score_delta, e.score);
      end
      tests++;
      if (bus.board_out !== e.board) begin
         fails++;
         $display("FAIL %s board_out: got %h want %h", nm, bus.board_out, e.board);
      end
      @(negedge clk);
      tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || int'(bus.rows_cleared) != e.cnt || bus.board_out !== e.board) begin
         fails++;
         $display("FAIL %s idle_hold: done %b busy %b rows %0d want done 0 busy 0 rows %0d", nm, bus.done, bus.busy, bus.rows_cleared, e.cnt);
      end
   endtask
   task automatic test_reset();
      rst_n = 0;
      bus.start = 1;
      bus.pause = 0;
      bus.board_in = '1;
      repeat (3) @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags: busy %b done %b want 0 0", bus.busy, bus.done);
      end
      tests++;
      if (bus.rows_cleared !== '0 || bus.clear_mask !== '0 || bus.score_delta !== '0) begin
         fails++;
         $display("FAIL reset_results: rows %0d mask %h score %0d want 0", bus.rows_cleared, bus.clear_mask, bus.score_delta);
      end
      tests++;
      if (bus.board_out !== '0) begin
         fails++;
         $display("FAIL reset_board: got %h want 0", bus.board_out);
      end
      bus.start = 0;
      rst_n = 1;
      @(negedge clk);
   endtask
   task automatic test_empty();
      run_job('0, 0, 0, -1, "empty");
   endtask
   task automatic test_single();
      brd_t b = '0;
      b = put_row(b, 21, '1);
      b = put_row(b, 20, 10'h008);
      run_job(b, 0, 0, -1, "single");
      tests++;
      if (bus.board_out[21*W +: W] !== 10'h008 || bus.board_out[20*W +: W] !== 10'h000) begin
         fails++;
         $display("FAIL single_rows: row21 %h row20 %h want 008 000", bus.board_out[21*W +: W], bus.board_out[20*W +: W]);
      end
   endtask
   task automatic test_tetris();
      brd_t b = '0;
      for (int r = 18; r <= 21; r++) b = put_row(b, r, '1);
      b = put_row(b, 17, 10'h155);
      run_job(b, 0, 0, -1, "tetris");
      tests++;
      if (bus.board_out[21*W +: W] !== 10'h155 || bus.score_delta !== 11'd1200) begin
         fails++;
         $display("FAIL tetris_row21: row21 %h score %0d want 155 1200", bus.board_out[21*W +: W], bus.score_delta);
      end
   endtask
   task automatic test_split();
      brd_t b = '0;
      b = put_row(b, 21, '1);
      b = put_row(b, 19, '1);
      b = put_row(b, 20, 10'h001);
      b = put_row(b, 18, 10'h200);
      run_job(b, 0, 0, -1, "split");
   endtask
   task automatic test_full_board();
      run_job('1, 0, 0, -1, "full_board");
   endtask
   task automatic test_pause();
      brd_t b = '0;
      b = put_row(b, 21, '1);
      b = put_row(b, 20, 10'h0f3);
      b = put_row(b, 16, '1);
      run_job(b, 0, 0, -1, "pause_ref");
      run_job(b, 5, 5, 12, "pause");
   endtask
   task automatic test_reset_mid();
      brd_t b = '0;
      b = put_row(b, 21, '1);
      b = put_row(b, 20, 10'h2a5);
      bus.board_in = b;
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      for (int c = 1; c < 10; c++) @(negedge clk);
      tests++;
      if (bus.rows_cleared !== 5'd1 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL midjob_progress: rows %0d busy %b want 1 1", bus.rows_cleared, bus.busy);
      end
      rst_n = 0;
      bus.start = 1;
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rows_cleared !== '0 || bus.clear_mask !== '0 || bus.score_delta !== '0 || bus.board_out !== '0) begin
         fails++;
         $display("FAIL midjob_reset: busy %b done %b rows %0d mask %h board %h want all 0", bus.busy, bus.done, bus.rows_cleared, bus.clear_mask, bus.board_out);
      end
      rst_n = 1;
      bus.start = 0;
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL midjob_start_ignored: busy %b want 0", bus.busy);
      end
      run_job(b, 0, 0, -1, "after_reset");
   endtask
   task automatic test_back_to_back();
      brd_t b;
      for (int j = 0; j < 4; j++) begin
         b = '0;
         for (int r = 0; r < H; r++) b = put_row(b, r, $urandom_range(0, 2) == 0 ? '1 : W'($urandom));
         run_job(b, 0, 0, -1, "b2b");
      end
   endtask
   initial begin
      bus.start = 0;
      bus.pause = 0;
      bus.board_in = '0;
      test_reset();
      test_empty();
      test_single();
      test_tetris();
      test_split();
      test_full_board();
      test_pause();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
